// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and the memory stage.
// Data wins ties unless a run of data grants has starved a waiting fetch.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned MAX_D_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    localparam int unsigned STREAK_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D
    } state_t;

    state_t              state;
    logic [STREAK_W-1:0] streak;
    logic                discard;

    logic elig_i;
    logic elig_d;
    logic streak_full;
    logic grant_d;
    logic grant_i;

    // Grant decision; a requester being acked this cycle is not eligible again yet
    always_comb begin
        elig_i      = if_req & ~if_ack & ~if_flush;
        elig_d      = d_req & ~d_ack;
        streak_full = (streak == STREAK_W'(MAX_D_STREAK));
        grant_d     = (state == IDLE) & elig_d & ~(elig_i & streak_full);
        grant_i     = (state == IDLE) & elig_i & ~grant_d;
    end

    assign stall_if  = if_req & ~if_ack;
    assign stall_mem = d_req & ~d_ack;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            streak    <= '0;
            discard   <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            if_ack    <= 1'b0;
            d_rdata   <= '0;
            d_ack     <= 1'b0;
        end else begin
            if_ack <= 1'b0;
            d_ack  <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        mem_req   <= 1'b1;
                        mem_we    <= d_we;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        state     <= BUSY_D;
                        if (elig_i && !streak_full) begin
                            streak <= streak + 1'b1;
                        end
                    end else if (grant_i) begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= if_addr;
                        state    <= BUSY_I;
                        streak   <= '0;
                    end
                end
                BUSY_I: begin
                    // A redirect at any point of the fetch, even its last cycle, drops the data
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        discard <= 1'b0;
                        state   <= IDLE;
                        if (!(discard || if_flush)) begin
                            if_rdata <= mem_rdata;
                            if_ack   <= 1'b1;
                        end
                    end else if (if_flush) begin
                        discard <= 1'b1;
                    end
                end
                BUSY_D: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        d_rdata <= mem_rdata;
                        d_ack   <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            if (!if_req) begin
                streak <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus concurrent random requesters,
// with expected responses queued at issue and compared by an independent monitor.
module tb_mem_port_arbiter;

    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned MAX = 4;

    logic          clk;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_flush;
    logic [DW-1:0] if_rdata;
    logic          if_ack;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_ack;
    logic          stall_if;
    logic          stall_mem;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;

    mem_port_arbiter #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .MAX_D_STREAK(MAX)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_flush (if_flush),
        .if_rdata (if_rdata),
        .if_ack   (if_ack),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_rdata  (d_rdata),
        .d_ack    (d_ack),
        .stall_if (stall_if),
        .stall_mem(stall_mem),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ack  (mem_ack)
    );

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] ref_mem [256];
    logic [DW-1:0] mem_arr [256];
    logic [DW-1:0] if_exp_q [$];
    logic [DW-1:0] d_exp_q  [$];

    logic          g_fetch_q [$];
    logic          g_we_q    [$];
    logic [AW-1:0] g_addr_q  [$];
    int            g_cyc_q   [$];

    int            wait_mode = -1;
    logic          mem_auto = 1'b1;
    logic          force_ack = 1'b0;
    logic [DW-1:0] force_rdata = '0;
    int            cyc = 0;
    int            n_if_ack = 0;
    int            last_d_ack_cyc = -1;
    int            last_mem_ack_cyc = -1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Memory: random or fixed wait, reads return stored words, writes echo ~wdata
    initial begin
        int  wcnt;
        bit  active;
        int  idx;
        wcnt   = 0;
        active = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            #1;
            mem_ack = 1'b0;
            if (rst || !mem_auto) begin
                active = 1'b0;
                if (!mem_auto) begin
                    mem_ack   = force_ack;
                    mem_rdata = force_rdata;
                end
            end else if (mem_req) begin
                if (!active) begin
                    active = 1'b1;
                    wcnt   = (wait_mode < 0) ? int'($urandom_range(0, 3)) : wait_mode;
                end
                if (wcnt == 0) begin
                    idx     = int'(mem_addr[9:2]);
                    mem_ack = 1'b1;
                    if (mem_we) begin
                        mem_arr[idx] = mem_wdata;
                        mem_rdata    = ~mem_wdata;
                    end else begin
                        mem_rdata = mem_arr[idx];
                    end
                    active = 1'b0;
                end else begin
                    wcnt--;
                end
            end
        end
    end

    // Monitor: response scoreboard, protocol checks and grant log
    initial begin
        logic [DW-1:0] last_if;
        logic [DW-1:0] last_d;
        logic [DW-1:0] exp;
        logic          prev_req;
        logic          prev_if_ack;
        logic          prev_d_ack;
        last_if = '0; last_d = '0; prev_req = 1'b0; prev_if_ack = 1'b0; prev_d_ack = 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (rst) begin
                last_if = '0; last_d = '0;
                prev_req = 1'b0; prev_if_ack = 1'b0; prev_d_ack = 1'b0;
            end else begin
                check("ack_exclusive", 32'(if_ack & d_ack), 32'd0);
                check("stall_if", 32'(stall_if), 32'(if_req & ~if_ack));
                check("stall_mem", 32'(stall_mem), 32'(d_req & ~d_ack));
                if (if_ack) begin
                    n_if_ack++;
                    check("if_ack_pulse", 32'(prev_if_ack), 32'd0);
                    if (if_exp_q.size() == 0) check("if_ack_unexpected", 32'd1, 32'd0);
                    else begin
                        exp = if_exp_q.pop_front();
                        check("if_rdata", if_rdata, exp);
                    end
                    last_if = if_rdata;
                end else begin
                    check("if_rdata_hold", if_rdata, last_if);
                end
                if (d_ack) begin
                    last_d_ack_cyc = cyc;
                    check("d_ack_pulse", 32'(prev_d_ack), 32'd0);
                    if (d_exp_q.size() == 0) check("d_ack_unexpected", 32'd1, 32'd0);
                    else begin
                        exp = d_exp_q.pop_front();
                        check("d_rdata", d_rdata, exp);
                    end
                    last_d = d_rdata;
                end else begin
                    check("d_rdata_hold", d_rdata, last_d);
                end
                if (mem_ack) last_mem_ack_cyc = cyc;
                if (mem_req && !prev_req) begin
                    g_fetch_q.push_back(!mem_we && (mem_addr < 32'h100));
                    g_we_q.push_back(mem_we);
                    g_addr_q.push_back(mem_addr);
                    g_cyc_q.push_back(cyc);
                end
                prev_req    = mem_req;
                prev_if_ack = if_ack;
                prev_d_ack  = d_ack;
            end
        end
    end

    task automatic wait_mem_req();
        for (int k = 0; k < 50 && !mem_req; k++) @(negedge clk);
        check("mem_req_seen", 32'(mem_req), 32'd1);
    endtask

    task automatic fetch_requester(int n);
        int got;
        for (int t = 0; t < n; t++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            if_addr = 32'($urandom_range(0, 63) * 4);
            if_exp_q.push_back(ref_mem[if_addr[9:2]]);
            if_req = 1'b1;
            got = 0;
            for (int k = 0; k < 400 && got == 0; k++) begin
                @(negedge clk);
                if (if_ack) begin
                    got = 1; if_req = 1'b0; if_flush = 1'b0;
                end else if (!if_flush && $urandom_range(0, 9) == 0) begin
                    if_flush = 1'b1;
                    if_addr  = 32'($urandom_range(0, 63) * 4);
                    void'(if_exp_q.pop_back());
                    if_exp_q.push_back(ref_mem[if_addr[9:2]]);
                end else begin
                    if_flush = 1'b0;
                end
            end
            check("if_ack_wait", 32'(got), 32'd1);
        end
    endtask

    task automatic data_requester(int n);
        int got;
        int idx;
        for (int t = 0; t < n; t++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            d_we    = 1'($urandom_range(0, 1));
            d_addr  = 32'h100 + 32'($urandom_range(0, 191) * 4);
            d_wdata = $urandom;
            idx     = int'(d_addr[9:2]);
            if (d_we) begin
                ref_mem[idx] = d_wdata;
                d_exp_q.push_back(~d_wdata);
            end else begin
                d_exp_q.push_back(ref_mem[idx]);
            end
            d_req = 1'b1;
            got = 0;
            for (int k = 0; k < 400 && got == 0; k++) begin
                @(negedge clk);
                if (d_ack) begin got = 1; d_req = 1'b0; end
            end
            check("d_ack_wait", 32'(got), 32'd1);
        end
    endtask

    initial begin
        int gs;
        int got_i;
        int got_d;
        int dacks;
        int acks_before;

        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = 32'h0A00_0000 ^ (32'(i) * 32'h0001_0203);
            mem_arr[i] = ref_mem[i];
        end
        ref_mem[4] = 32'h0050_0093;
        mem_arr[4] = 32'h0050_0093;

        rst = 1'b1; if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_if_ack", 32'(if_ack), 32'd0);
        check("rst_if_rdata", if_rdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single fetch with zero memory wait: ack two cycles after the request
        wait_mode = 0;
        if_addr = 32'h10; if_req = 1'b1;
        if_exp_q.push_back(32'h0050_0093);
        @(negedge clk);
        check("zw_c1_mem_req", 32'(mem_req), 32'd1);
        check("zw_c1_mem_we", 32'(mem_we), 32'd0);
        check("zw_c1_mem_addr", mem_addr, 32'h10);
        check("zw_c1_if_ack", 32'(if_ack), 32'd0);
        @(negedge clk);
        check("zw_c2_if_ack", 32'(if_ack), 32'd1);
        check("zw_c2_if_rdata", if_rdata, 32'h0050_0093);
        check("zw_c2_mem_we", 32'(mem_we), 32'd0);
        if_req = 1'b0;
        @(negedge clk);
        check("zw_c3_if_ack", 32'(if_ack), 32'd0);
        repeat (2) @(negedge clk);

        // Simultaneous fetch and store: store first, fetch granted in the d_ack cycle
        wait_mode = -1;
        gs = g_fetch_q.size();
        if_addr = 32'h30; if_req = 1'b1;
        if_exp_q.push_back(ref_mem[12]);
        d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF; d_req = 1'b1;
        ref_mem[128] = 32'hDEAD_BEEF;
        d_exp_q.push_back(~32'hDEAD_BEEF);
        got_i = 0; got_d = 0;
        for (int k = 0; k < 200 && !(got_i == 1 && got_d == 1); k++) begin
            @(negedge clk);
            if (d_ack) begin d_req = 1'b0; got_d = 1; end
            if (if_ack) begin if_req = 1'b0; got_i = 1; end
        end
        check("sim_done", 32'(got_i + got_d), 32'd2);
        check("sim_grants", 32'(g_fetch_q.size() - gs), 32'd2);
        if (g_fetch_q.size() >= gs + 2) begin
            check("sim_first_is_data", 32'(g_fetch_q[gs]), 32'd0);
            check("sim_first_we", 32'(g_we_q[gs]), 32'd1);
            check("sim_first_addr", g_addr_q[gs], 32'h200);
            check("sim_second_addr", g_addr_q[gs+1], 32'h30);
            check("sim_second_we", 32'(g_we_q[gs+1]), 32'd0);
            check("sim_fetch_in_dack", 32'(g_cyc_q[gs+1]), 32'(last_d_ack_cyc + 1));
        end
        repeat (2) @(negedge clk);

        // Starvation guard: fetch redirected in every d_ack cycle, data re-requests at once
        wait_mode = 1;
        gs = g_fetch_q.size();
        if_addr = 32'h20; if_req = 1'b1;
        if_exp_q.push_back(ref_mem[8]);
        d_we = 1'b0; d_addr = 32'h100; d_req = 1'b1;
        d_exp_q.push_back(ref_mem[64]);
        dacks = 0; got_i = 0;
        for (int k = 0; k < 300 && !(got_i == 1 && dacks == 5); k++) begin
            @(negedge clk);
            if_flush = 1'b0;
            if (if_ack) begin if_req = 1'b0; got_i = 1; end
            if (d_ack) begin
                dacks++;
                if (dacks < 5) d_exp_q.push_back(ref_mem[64]);
                else d_req = 1'b0;
                if (if_req) if_flush = 1'b1;
            end
        end
        if_flush = 1'b0;
        check("starve_done", 32'(got_i + dacks), 32'd6);
        check("starve_grants", 32'(g_fetch_q.size() - gs), 32'd6);
        if (g_fetch_q.size() >= gs + 6) begin
            for (int j = 0; j < 6; j++) begin
                check($sformatf("starve_grant%0d_is_fetch", j), 32'(g_fetch_q[gs+j]),
                      (j == 4) ? 32'd1 : 32'd0);
            end
        end
        repeat (2) @(negedge clk);

        // Flush during a 3-wait fetch: discarded, redirect target served right after
        wait_mode = 3;
        gs = g_fetch_q.size();
        acks_before = n_if_ack;
        if_addr = 32'h50; if_req = 1'b1;
        if_exp_q.push_back(ref_mem[20]);
        @(negedge clk);
        wait_mem_req();
        if_flush = 1'b1; if_addr = 32'h40;
        void'(if_exp_q.pop_back());
        if_exp_q.push_back(ref_mem[16]);
        @(negedge clk);
        if_flush = 1'b0;
        got_i = 0;
        for (int k = 0; k < 100 && got_i == 0; k++) begin
            @(negedge clk);
            if (if_ack) begin if_req = 1'b0; got_i = 1; end
        end
        check("flush_acks", 32'(n_if_ack - acks_before), 32'd1);
        check("flush_grants", 32'(g_fetch_q.size() - gs), 32'd2);
        if (g_fetch_q.size() >= gs + 2) begin
            check("flush_first_addr", g_addr_q[gs], 32'h50);
            check("flush_second_addr", g_addr_q[gs+1], 32'h40);
            check("flush_regrant_gap", 32'(g_cyc_q[gs+1] - g_cyc_q[gs]), 32'd5);
        end
        repeat (2) @(negedge clk);

        // Flush in IDLE only blocks the grant for that one cycle
        wait_mode = 0;
        if_addr = 32'h60; if_req = 1'b1; if_flush = 1'b1;
        @(negedge clk);
        check("iflush_no_grant", 32'(mem_req), 32'd0);
        if_flush = 1'b0; if_addr = 32'h64;
        if_exp_q.push_back(ref_mem[25]);
        @(negedge clk);
        check("iflush_grant", 32'(mem_req), 32'd1);
        check("iflush_addr", mem_addr, 32'h64);
        @(negedge clk);
        check("iflush_ack", 32'(if_ack), 32'd1);
        if_req = 1'b0;
        repeat (2) @(negedge clk);

        // Random concurrent traffic
        wait_mode = -1;
        fork
            fetch_requester(60);
            data_requester(60);
        join
        repeat (4) @(negedge clk);

        // Reset while a store is in flight; a late mem_ack must be ignored
        mem_auto = 1'b0;
        d_we = 1'b1; d_addr = 32'h104; d_wdata = 32'h55; d_req = 1'b1;
        @(negedge clk);
        wait_mem_req();
        rst = 1'b1; d_req = 1'b0;
        @(negedge clk);
        check("mrst_mem_req", 32'(mem_req), 32'd0);
        check("mrst_mem_we", 32'(mem_we), 32'd0);
        check("mrst_mem_addr", mem_addr, 32'd0);
        check("mrst_mem_wdata", mem_wdata, 32'd0);
        check("mrst_if_rdata", if_rdata, 32'd0);
        check("mrst_d_rdata", d_rdata, 32'd0);
        check("mrst_acks", 32'(if_ack | d_ack), 32'd0);
        rst = 1'b0;
        force_rdata = 32'h1234_5678; force_ack = 1'b1;
        @(negedge clk);
        force_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("late_ack_no_d_ack", 32'(d_ack), 32'd0);
            check("late_ack_no_req", 32'(mem_req), 32'd0);
        end
        check("late_ack_d_rdata", d_rdata, 32'd0);
        mem_auto = 1'b1;

        check("if_queue_drained", 32'(if_exp_q.size()), 32'd0);
        check("d_queue_drained", 32'(d_exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified instruction/data memory between two requesters: the instruction fetch stage (read-only) and the memory access stage (read/write).
- The memory access stage has priority, since it holds the older instruction. A streak counter prevents fetch starvation.
- Discards in-flight fetches when the execute stage redirects the PC on a taken branch or jump.
- Sits between the pipeline stages and the memory. Generates the stall indications the pipeline uses to freeze stages.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width of all ports.
- MAX_D_STREAK, 4, maximum consecutive data grants while a fetch is waiting. Range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- if_req  in  1  fetch request. Held high until if_ack.
- if_addr  in  ADDR_W  fetch address. Stable while if_req is high.
- if_flush  in  1  PC redirect this cycle; the current or pending fetch is discarded.
- if_rdata  out  DATA_W  fetched word. Valid while if_ack is high.
- if_ack  out  1  one-cycle fetch-complete pulse.
- d_req  in  1  data request. Held high until d_ack.
- d_we  in  1  1 = store, 0 = load. Stable while d_req is high.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_rdata  out  DATA_W  load data. Valid while d_ack is high.
- d_ack  out  1  one-cycle data-complete pulse.
- stall_if  out  1  combinational: if_req & ~if_ack.
- stall_mem  out  1  combinational: d_req & ~d_ack.
- mem_req  out  1  memory request, registered. Held until mem_ack.
- mem_we  out  1  memory write enable, registered.
- mem_addr  out  ADDR_W  registered.
- mem_wdata  out  DATA_W  registered.
- mem_rdata  in  DATA_W  memory read data. Valid with mem_ack.
- mem_ack  in  1  memory completion. Single-cycle pulse, 0..N wait cycles.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - State=IDLE.
  - mem_req, mem_we, if_ack, d_ack, discard flag and streak counter all 0.
  - mem_addr, mem_wdata, if_rdata, d_rdata all 0.
  - An in-flight transaction is abandoned. A mem_ack arriving after reset is ignored.
- States: IDLE, BUSY_I, BUSY_D.
- IDLE arbitration:
  - Eligible fetch = if_req & ~if_ack & ~if_flush.
  - Eligible data = d_req & ~d_ack.
  - Both eligible: data wins, unless streak == MAX_D_STREAK, in which case fetch wins.
- On a grant:
  - Register the winner's addr/we/wdata onto the mem_* outputs. A fetch forces mem_we=0.
  - Set mem_req=1 and go to BUSY_x.
  - mem_req therefore rises the cycle after the grant decision.
- Streak counter:
  - Increments on a data grant while a fetch is eligible.
  - Clears on a fetch grant, or whenever if_req=0.
  - Saturates at MAX_D_STREAK.
- BUSY_x:
  - mem_req and the mem_* outputs are held until mem_ack=1.
  - On mem_ack: mem_req=0 and mem_we=0 next cycle; state goes to IDLE.
  - Capture mem_rdata into the owner's rdata register and assert the owner's ack next cycle for exactly 1 cycle.
  - A store still pulses d_ack; d_rdata then holds the value on mem_rdata.
- Latency with zero memory wait: req seen at cycle 0 → mem_req at cycle 1 → mem_ack at cycle 1 → ack at cycle 2.
- Back-to-back: in the ack cycle the arbiter is in IDLE and ignores the acked requester. The other requester may be granted in that cycle. The same requester's next request is granted no earlier than the following cycle.
- Flush:
  - if_flush=1 in BUSY_I (including the mem_ack cycle) sets the discard flag.
  - On completion with discard set: if_ack stays 0, if_rdata is unchanged, and the flag clears.
  - if_flush in IDLE blocks a fetch grant that cycle only.
  - if_flush has no effect on BUSY_D.
- mem_ack in IDLE is ignored.
- if_ack and d_ack are never high in the same cycle.

Test Plan:
- Reset mid-transaction: rst=1 while BUSY_D with mem_req=1 → next cycle all outputs 0 and state IDLE. A late mem_ack produces no d_ack.
- Single fetch, zero wait: if_addr=0x10, mem_ack same cycle as mem_req, mem_rdata=0x00500093 → if_ack=1 for 1 cycle at cycle 2 with if_rdata=0x00500093; mem_we=0 throughout.
- Simultaneous requests: if_req and d_req (store, d_addr=0x200, d_wdata=0xDEADBEEF) in the same cycle → store is granted first with mem_we=1, mem_addr=0x200; fetch is granted in the d_ack cycle. stall_if=1 until if_ack.
- Starvation guard (MAX_D_STREAK=4): if_req held, d_req re-raised every cycle after d_ack → exactly 4 data grants, then a fetch grant, then the counter resets to 0.
- Flush during fetch: if_flush pulsed while BUSY_I with 3 memory wait cycles → no if_ack and if_rdata unchanged. A new fetch to 0x40 is granted in the next IDLE cycle and returns normally.
- Flush in IDLE: if_flush with if_req, d_req=0 → no grant that cycle; grant the next cycle, mem_addr = the new if_addr.
